// File: rtl/tensor_fetch_ctrl.sv
// Read-side sequencer for the tensor weight/bias memory.
// Walks bias then weight words per row group and streams them out.
module tensor_fetch_ctrl #(
    parameter int unsigned W1_BASE   = 0,
    parameter int unsigned B1_BASE   = 57600,
    parameter int unsigned W2_BASE   = 57664,
    parameter int unsigned B2_BASE   = 57728,
    parameter int unsigned L1_GROUPS = 16,
    parameter int unsigned L1_WPG    = 3600,
    parameter int unsigned L1_BPG    = 4,
    parameter int unsigned L2_GROUPS = 1,
    parameter int unsigned L2_WPG    = 64,
    parameter int unsigned L2_BPG    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        layer_sel,
    input  logic        mmio_wen,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_is_bias,
    output logic        out_last,
    output logic [3:0]  out_group,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_WEIGHT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic        layer;
    logic [15:0] idx;
    logic [4:0]  grp;
    logic [31:0] bptr;
    logic [31:0] wptr;

    logic [15:0] bpg_m1;
    logic [15:0] wpg_m1;
    logic [4:0]  groups;
    logic        bias_end;
    logic        wt_end;
    logic        accept;
    logic        issuing;

    logic        inflight;
    logic        fl_bias;
    logic        fl_last;
    logic [3:0]  fl_grp;

    logic [31:0] fd [2];
    logic        fb [2];
    logic        flst [2];
    logic [3:0]  fg [2];
    logic        head;
    logic        tail;
    logic [1:0]  occ;
    logic [1:0]  occ_nxt;
    logic        push;
    logic        pop;

    always_comb begin
        bpg_m1 = layer ? 16'(L2_BPG - 1) : 16'(L1_BPG - 1);
        wpg_m1 = layer ? 16'(L2_WPG - 1) : 16'(L1_WPG - 1);
        groups = layer ? 5'(L2_GROUPS) : 5'(L1_GROUPS);
    end

    assign bias_end = (idx == bpg_m1);
    assign wt_end   = (idx == wpg_m1);
    assign accept   = (state == S_IDLE) && start;

    // Buffered words plus the read in flight must fit the 2-entry buffer.
    assign issuing = ((state == S_BIAS) || (state == S_WEIGHT))
                   && !mmio_wen
                   && ((occ + {1'b0, inflight}) < 2'd2);

    assign mem_ren = issuing;

    always_comb begin
        mem_raddr = '0;
        if (state == S_BIAS) begin
            mem_raddr = bptr;
        end else if (state == S_WEIGHT) begin
            mem_raddr = wptr;
        end
    end

    // An empty buffer forwards the returning read word directly.
    assign pop     = (occ != 2'd0) && out_ready;
    assign push    = inflight && !((occ == 2'd0) && out_ready);
    assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

    assign out_valid = (occ != 2'd0) || inflight;

    always_comb begin
        out_data    = '0;
        out_is_bias = 1'b0;
        out_last    = 1'b0;
        out_group   = '0;
        if (occ != 2'd0) begin
            out_data    = fd[head];
            out_is_bias = fb[head];
            out_last    = flst[head];
            out_group   = fg[head];
        end else if (inflight) begin
            out_data    = mem_rdata;
            out_is_bias = fl_bias;
            out_last    = fl_last;
            out_group   = fl_grp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_BIAS;
            end
            S_BIAS: begin
                if (issuing && bias_end) state_nxt = S_WEIGHT;
            end
            S_WEIGHT: begin
                if (issuing && wt_end) begin
                    if ((grp + 5'd1) < groups) state_nxt = S_BIAS;
                    else                       state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_nxt == 2'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_BIAS) || (state == S_WEIGHT)
                || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            layer    <= 1'b0;
            idx      <= '0;
            grp      <= '0;
            bptr     <= '0;
            wptr     <= '0;
            inflight <= 1'b0;
            fl_bias  <= 1'b0;
            fl_last  <= 1'b0;
            fl_grp   <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            occ      <= '0;
            for (int k = 0; k < 2; k++) begin
                fd[k]   <= '0;
                fb[k]   <= 1'b0;
                flst[k] <= 1'b0;
                fg[k]   <= '0;
            end
        end else begin
            inflight <= issuing;
            if (accept) begin
                layer <= layer_sel;
                idx   <= '0;
                grp   <= '0;
                bptr  <= layer_sel ? 32'(B2_BASE) : 32'(B1_BASE);
                wptr  <= layer_sel ? 32'(W2_BASE) : 32'(W1_BASE);
            end
            if (issuing) begin
                fl_bias <= (state == S_BIAS);
                fl_last <= (state == S_WEIGHT) && wt_end;
                fl_grp  <= grp[3:0];
                if (state == S_BIAS) begin
                    bptr <= bptr + 32'd1;
                    idx  <= bias_end ? '0 : idx + 16'd1;
                end else begin
                    wptr <= wptr + 32'd1;
                    if (wt_end) begin
                        idx <= '0;
                        grp <= grp + 5'd1;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
            end
            if (push) begin
                fd[tail]   <= mem_rdata;
                fb[tail]   <= fl_bias;
                flst[tail] <= fl_last;
                fg[tail]   <= fl_grp;
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_tensor_fetch_ctrl.sv
// Scoreboard bench for tensor_fetch_ctrl: expected addresses and words
// are queued by the stimulus and consumed by a negedge monitor.
module tb_tensor_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        layer_sel = 1'b0;
    logic        mmio_wen = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_is_bias;
    logic        out_last;
    logic [3:0]  out_group;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    tensor_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .layer_sel   (layer_sel),
        .mmio_wen    (mmio_wen),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_is_bias (out_is_bias),
        .out_last    (out_last),
        .out_group   (out_group),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [31:0] mval(input logic [31:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction

    // Registered read port: data appears the cycle after mem_ren.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mval(mem_raddr);
    end

    typedef struct packed {
        logic [31:0] d;
        logic        b;
        logic        l;
        logic [3:0]  g;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] addr_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_iss = 0;
    int n_acc = 0;
    int run_words = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ren = 0;
    int last_hs = 0;
    logic prev_stall = 1'b0;
    ent_t prev_ent;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic fail_unexp(input string nm, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h with nothing required", nm, act);
    endtask

    always @(negedge clk) begin
        ent_t cur;
        cyc++;
        cur = {out_data, out_is_bias, out_last, out_group};
        if (!rst) begin
            exp_q.delete();
            addr_q.delete();
            n_iss = 0;
            n_acc = 0;
            prev_stall = 1'b0;
        end else begin
            if (mmio_wen) chk("ren_during_mmio", 64'(mem_ren), 64'd0);
            if (mem_ren) begin
                last_ren = cyc;
                n_iss++;
                if (addr_q.size() == 0) fail_unexp("raddr", 64'(mem_raddr));
                else chk("raddr", 64'(mem_raddr), 64'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(cur), 64'(prev_ent));
            end
            if (out_valid && out_ready) begin
                n_acc++;
                run_words++;
                last_hs = cyc;
                if (exp_q.size() == 0) fail_unexp("word", 64'(cur));
                else chk("word", 64'(cur), 64'(exp_q.pop_front()));
            end
            if (mem_ren) chk("outstanding_le2", 64'((n_iss - n_acc) <= 2), 64'd1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last_word",
                    64'((exp_q.size() == 0) && (cyc > last_hs) && !busy), 64'd1);
            end
            prev_stall = out_valid && !out_ready;
            prev_ent = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_layer(input bit l, input int ng);
        int unsigned bb, wb, bpg, wpg, a;
        ent_t e;
        bb  = l ? 57728 : 57600;
        wb  = l ? 57664 : 0;
        bpg = l ? 3 : 4;
        wpg = l ? 64 : 3600;
        for (int g = 0; g < ng; g++) begin
            for (int i = 0; i < int'(bpg); i++) begin
                a = bb + g * bpg + i;
                addr_q.push_back(a);
                e = {mval(a), 1'b1, 1'b0, 4'(g)};
                exp_q.push_back(e);
            end
            for (int i = 0; i < int'(wpg); i++) begin
                a = wb + g * wpg + i;
                addr_q.push_back(a);
                e = {mval(a), 1'b0, (i == int'(wpg) - 1), 4'(g)};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ctl"},
            64'({mem_ren, out_valid, out_is_bias, out_last, out_group, busy, done}),
            64'd0);
        chk({nm, "_raddr"}, 64'(mem_raddr), 64'd0);
        chk({nm, "_data"}, 64'(out_data), 64'd0);
    endtask

    // mode 0: free run, 1: backpressure, 2: MMIO collision, 3: start while busy
    task automatic run_l2(input int mode, input string nm);
        int d0;
        bit seen;
        push_layer(1'b1, 1);
        run_words = 0;
        d0 = done_cnt;
        seen = 1'b0;
        out_ready = (mode != 1);
        mmio_wen = 1'b0;
        start = 1'b1;
        layer_sel = 1'b1;
        tick();
        start = 1'b0;
        layer_sel = 1'b0;
        for (int c = 1; c < 400 && !seen; c++) begin
            case (mode)
                1: out_ready = (c >= 20 && c < 30) ? 1'b0 : (c % 2 == 0);
                2: mmio_wen = (c >= 5 && c <= 9);
                3: start = (c == 10);
                default: ;
            endcase
            tick();
            if (done_cnt > d0) seen = 1'b1;
        end
        mmio_wen = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        repeat (5) tick();
        chk({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({nm, "_words"}, 64'(run_words), 64'd67);
        if (mode == 0) chk({nm, "_done_lat"}, 64'(done_cyc - last_ren), 64'd2);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int c;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

        run_l2(0, "l2_basic");
        run_l2(1, "l2_backpressure");
        run_l2(2, "l2_mmio");
        run_l2(3, "l2_start_busy");

        push_layer(1'b0, 3);
        run_words = 0;
        start = 1'b1;
        layer_sel = 1'b0;
        tick();
        start = 1'b0;
        c = 0;
        while (run_words < 2 * 3604 + 5 && c < 9000) begin
            tick();
            c++;
        end
        chk("l1_reach_group2", 64'(run_words >= 2 * 3604 + 5), 64'd1);
        chk("l1_group2", 64'(out_group), 64'd2);
        out_ready = 1'b0;
        repeat (4) tick();
        chk("l1_buf_held", 64'(out_valid), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

        run_l2(0, "l2_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, required finish before 3000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tensor_fetch_ctrl.md
Name: tensor_fetch_ctrl

Overview:
Read-side sequencer for the tensor weight/bias memory. On a start command for layer 1 or layer 2, it walks the packed weight and bias address map group by group. It issues single-cycle read requests to the memory's registered read port and delivers the returned words as a valid/ready stream to the MAC datapath. It never issues a read in a cycle where the MMIO write port is active. It tolerates the one-cycle read latency and arbitrary downstream backpressure without losing or duplicating words.

Parameters:
W1_BASE, 0, word address of first W1 word
B1_BASE, 57600, word address of first b1 word
W2_BASE, 57664, word address of first W2 word
B2_BASE, 57728, word address of first b2 word
L1_GROUPS, 16, layer-1 row groups (4 int8 rows packed per word)
L1_WPG, 3600, layer-1 weight words per group
L1_BPG, 4, layer-1 bias words per group
L2_GROUPS, 1, layer-2 row groups
L2_WPG, 64, layer-2 weight words per group
L2_BPG, 3, layer-2 bias words per group

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
start  input  1  one-cycle command pulse; accepted only in IDLE
layer_sel  input  1  0 = layer 1, 1 = layer 2; sampled with start
mmio_wen  input  1  MMIO write to memory this cycle; suppresses mem_ren
mem_ren  output  1  read enable to tensor memory
mem_raddr  output  32  word read address
mem_rdata  input  32  read data, valid the cycle after mem_ren
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts when out_valid & out_ready
out_data  output  32  memory word
out_is_bias  output  1  1 = bias word, 0 = weight word
out_last  output  1  last weight word of current group
out_group  output  4  group index of current word
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse after final word accepted

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE. mem_ren, out_valid, busy, done=0. mem_raddr=0. Counters and the 2-entry output buffer are cleared. Reset mid-run abandons the run; any in-flight read data is discarded.
- States: IDLE, BIAS, WEIGHT, DRAIN, DONE.
- IDLE: on start=1, latch layer_sel, clear group/index counters, go to BIAS, set busy=1. start in any other state is ignored.
- BIAS: issue reads at bbase + g*BPG + i for i = 0..BPG-1, then go to WEIGHT.
- WEIGHT: issue reads at wbase + g*WPG + i for i = 0..WPG-1. After the last word, increment g. If g < GROUPS go to BIAS; otherwise go to DRAIN.
- DRAIN: wait until the output buffer is empty and no read is in flight, then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- mem_raddr is a 32-bit sum; high bits are zero for all legal maps.
- Issue rule: mem_ren=1 in a cycle only if all of the following hold:
  - state is BIAS or WEIGHT;
  - mmio_wen=0;
  - (buffer occupancy + in-flight reads) < 2.
  An address counter advances only when mem_ren=1.
- Timing: start at edge N gives the first mem_ren registered in cycle N+1; the first out_valid is in cycle N+2 if the buffer is empty.
- Output buffer: 2-entry FIFO of {data, is_bias, last, group}, captured the cycle after each mem_ren. Capture and pop in the same cycle are allowed.
- Throughput: with out_ready=1 and mmio_wen=0, one word per cycle.
- Stream ordering per group: BPG bias words, then WPG weight words. out_last=1 only on weight index WPG-1.
- While out_valid=1 and out_ready=0, out_data and the sideband fields hold stable.
- mmio_wen=1 only stalls issue. It never drops words, and mem_ren & mmio_wen is never 1.
- done pulses only after the final word handshake.

Test Plan:
- Layer 2, out_ready=1, mmio_wen=0: mem_raddr sequence 57728..57730 then 57664..57727. Output is 67 words, first 3 with out_is_bias=1, out_last only on word 67. done exactly once, 2 cycles after the last mem_ren.
- Layer 1 group boundary: after weight 3599 (addr 3599, out_last=1, out_group=0), the next reads are 57604..57607 then 3600. out_group=1 on these.
- Backpressure: out_ready toggled 1/0 each cycle and held 0 for 10 cycles mid-run. No more than 2 reads outstanding. The output word sequence is identical to the unstalled run, and fields are stable while stalled.
- MMIO collision: mmio_wen=1 for cycles 5-9 of a layer-2 run. mem_ren=0 in those cycles, addresses resume without a skip, and all 67 words are delivered.
- Reset mid-run: rst=0 during layer-1 group 2 with the buffer full. The next cycle has all outputs 0 and state IDLE. A new layer-2 start produces a clean 67-word run.
- start pulsed while busy: ignored; the run completes with one done, and layer_sel is not re-sampled.
